poly_music_mixer: RTL and testbench

Parametrised multi-voice output stage for the music player. It mixes VOICES independent note-player sample streams into one signed codec sample. The sum is attenuated by a run-time volume, saturated, and released once per codec frame together with the per-frame generate_next_sample request. It replaces the single-voice sample path between the note players and the AC97 interface.

---
 rtl/poly_music_mixer.sv | 162 ++++++++++++++++
 tb/tb_poly_music_mixer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_music_mixer.sv
// rtl/poly_music_mixer.sv - multi-voice sample mixer with volume attenuation and saturation
module poly_music_mixer #(
   parameter int VOICES   = 2,
   parameter int SAMPLE_W = 16,
   parameter int VOL_W    = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          play,
   input  logic                          New_Frame,
   input  logic [VOICES*SAMPLE_W-1:0]    voice_sample,
   input  logic [VOICES-1:0]             voice_valid,
   input  logic [VOICES-1:0]             voice_enable,
   input  logic [VOL_W-1:0]              volume,
   input  logic                          clear_status,
   output logic                          generate_next_sample,
   output logic signed [SAMPLE_W-1:0]    sample_out,
   output logic                          clip,
   output logic [VOICES-1:0]             missing,
   output logic                          frame_overrun
);
   // Three guard bits cover the sum of up to eight full-scale voices.
   localparam int ACC_W = SAMPLE_W + 3;
   localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{4{1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{4{1'b1}}, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_SUM, ST_SAT} state_t;

   state_t                      state;
   state_t                      state_next;
   logic                        sync1;
   logic                        sync2;
   logic                        sync3;
   logic                        frame_edge;
   logic signed [SAMPLE_W-1:0]  hold [VOICES];
   logic [VOICES-1:0]           ready;
   logic [IDX_W-1:0]            idx;
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     addend;
   logic signed [ACC_W-1:0]     shifted;
   logic signed [ACC_W-1:0]     limited_val;
   logic                        limited;
   logic                        cur_enable;
   logic signed [SAMPLE_W-1:0]  cur_hold;
   logic [VOICES-1:0]           miss_set;

   assign frame_edge = sync2 & ~sync3;
   assign cur_enable = voice_enable[idx];
   assign cur_hold   = hold[idx];
   assign addend     = cur_enable ? {{3{cur_hold[SAMPLE_W-1]}}, cur_hold} : '0;

   // Bring the codec frame level into the clk domain and keep one extra stage for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= New_Frame;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Mixer state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next state: frame edge starts a mix, one cycle per voice, then one saturation cycle.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (frame_edge) state_next = ST_SUM;
         ST_SUM:  if (idx == LAST_IDX) state_next = ST_SAT;
         ST_SAT:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Attenuate the accumulated sum and clamp it into the codec sample range.
   always_comb begin
      shifted     = acc >>> volume;
      limited_val = shifted;
      limited     = 1'b0;
      if (shifted > SAT_MAX) begin
         limited_val = SAT_MAX;
         limited     = 1'b1;
      end else if (shifted < SAT_MIN) begin
         limited_val = SAT_MIN;
         limited     = 1'b1;
      end
   end

   // An enabled voice with no fresh sample while playing is flagged when it is summed.
   always_comb begin
      miss_set = '0;
      if (state == ST_SUM && cur_enable && !ready[idx] && play) miss_set[idx] = 1'b1;
   end

   // Per-voice capture; a new strobe beats the clear done when that voice is summed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < VOICES; i++) hold[i] <= '0;
         ready <= '0;
      end else begin
         for (int i = 0; i < VOICES; i++) begin
            if (voice_valid[i]) begin
               hold[i]  <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
               ready[i] <= 1'b1;
            end else if (state == ST_SUM && idx == IDX_W'(i)) begin
               ready[i] <= 1'b0;
            end
         end
      end
   end

   // Accumulator and voice index walk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         idx <= '0;
      end else if (state == ST_IDLE && frame_edge) begin
         acc <= '0;
         idx <= '0;
      end else if (state == ST_SUM) begin
         acc <= acc + addend;
         idx <= idx + IDX_W'(1);
      end
   end

   // Registered outputs: released in the saturation cycle, muted when not playing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_out           <= '0;
         generate_next_sample <= 1'b0;
         clip                 <= 1'b0;
      end else begin
         generate_next_sample <= 1'b0;
         clip                 <= 1'b0;
         if (state == ST_SAT) begin
            generate_next_sample <= play;
            clip                 <= play & limited;
            sample_out           <= play ? limited_val[SAMPLE_W-1:0] : '0;
         end
      end
   end

   // Sticky status; a set in the same cycle as clear_status wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         missing       <= '0;
         frame_overrun <= 1'b0;
      end else begin
         missing       <= (clear_status ? '0 : missing) | miss_set;
         frame_overrun <= (frame_overrun & ~clear_status) | (frame_edge && state != ST_IDLE);
      end
   end
endmodule

// File: tb/tb_poly_music_mixer.sv
// tb/tb_poly_music_mixer.sv - randomized and directed bench for poly_music_mixer
module tb_poly_music_mixer;
   localparam int V  = 2;
   localparam int SW = 16;
   localparam int VW = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              play;
   logic              New_Frame;
   logic [V*SW-1:0]   voice_sample;
   logic [V-1:0]      voice_valid;
   logic [V-1:0]      voice_enable;
   logic [VW-1:0]     volume;
   logic              clear_status;
   logic              generate_next_sample;
   logic [SW-1:0]     sample_out;
   logic              clip;
   logic [V-1:0]      missing;
   logic              frame_overrun;

   poly_music_mixer #(.VOICES(V), .SAMPLE_W(SW), .VOL_W(VW)) dut (
      .clk                  (clk),
      .reset                (reset),
      .play                 (play),
      .New_Frame            (New_Frame),
      .voice_sample         (voice_sample),
      .voice_valid          (voice_valid),
      .voice_enable         (voice_enable),
      .volume               (volume),
      .clear_status         (clear_status),
      .generate_next_sample (generate_next_sample),
      .sample_out           (sample_out),
      .clip                 (clip),
      .missing              (missing),
      .frame_overrun        (frame_overrun)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_hold [V];
   bit m_ready [V];
   int m_missing;
   bit m_overrun;
   int m_sample;
   int m_gns;
   int m_clip;

   task automatic check(input string tag, input logic signed [31:0] got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < V; i++) begin
         m_hold[i]  = 0;
         m_ready[i] = 0;
      end
      m_missing = 0;
      m_overrun = 0;
      m_sample  = 0;
   endtask

   // mix of one frame from the rules: enabled sum, arithmetic shift, clamp
   task automatic model_frame(input bit p_sum, input bit p_sat);
      int sum;
      int sh;
      int sat;
      bit lim;
      sum = 0;
      for (int i = 0; i < V; i++) begin
         if (voice_enable[i]) begin
            sum += m_hold[i];
            if (!m_ready[i] && p_sum) m_missing |= (1 << i);
         end
         m_ready[i] = 0;
      end
      sh  = sum >>> volume;
      lim = 0;
      sat = sh;
      if (sh > 32767)  begin sat = 32767;  lim = 1; end
      if (sh < -32768) begin sat = -32768; lim = 1; end
      m_gns    = p_sat ? 1 : 0;
      m_clip   = (p_sat && lim) ? 1 : 0;
      m_sample = p_sat ? sat : 0;
   endtask

   task automatic load(input logic [V-1:0] mask, input int a, input int b);
      if (mask != 0) begin
         @(negedge clk);
         voice_sample = {b[SW-1:0], a[SW-1:0]};
         voice_valid  = mask;
         @(negedge clk);
         voice_valid  = '0;
         if (mask[0]) begin m_hold[0] = a; m_ready[0] = 1; end
         if (mask[1]) begin m_hold[1] = b; m_ready[1] = 1; end
      end
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_status = 1'b1;
      @(negedge clk);
      clear_status = 1'b0;
      m_missing = 0;
      m_overrun = 0;
   endtask

   // mode 0: normal frame, 1: play dropped during SUM, 2: second edge while mixing
   task automatic run_frame(input string tag, input int mode);
      int gcount;
      int ccount;
      int first;
      bit p;
      gcount = 0;
      ccount = 0;
      first  = 0;
      p      = play;
      @(negedge clk);
      New_Frame = 1'b1;
      for (int n = 1; n <= V + 10; n++) begin
         @(posedge clk);
         #1;
         if (generate_next_sample) begin
            gcount++;
            if (first == 0) first = n;
         end
         if (clip) ccount++;
         if (mode == 1 && n == 3) play = 1'b0;
         if (mode == 2) begin
            if (n == 1) New_Frame = 1'b0;
            if (n == 2) New_Frame = 1'b1;
            if (n == 4) New_Frame = 1'b0;
         end else if (n == 3) begin
            New_Frame = 1'b0;
         end
      end
      model_frame(p, (mode == 1) ? 1'b0 : p);
      if (mode == 2) m_overrun = 1;
      check({tag, " sample"}, $signed(sample_out), m_sample);
      check({tag, " gen_pulses"}, gcount, m_gns);
      // latency is VOICES+4 clocks counted from the edge where New_Frame rises
      if (m_gns == 1) check({tag, " latency"}, first, V + 4);
      check({tag, " clip_pulses"}, ccount, m_clip);
      check({tag, " missing"}, missing, m_missing);
      check({tag, " overrun"}, frame_overrun, m_overrun);
      if (mode == 1) play = 1'b1;
   endtask

   initial begin
      int a;
      int b;
      logic [V-1:0] mask;
      reset        = 1'b0;
      play         = 1'b1;
      New_Frame    = 1'b0;
      voice_sample = '0;
      voice_valid  = '0;
      voice_enable = 2'b11;
      volume       = '0;
      clear_status = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst sample", $signed(sample_out), 0);
      check("rst gen", generate_next_sample, 0);
      check("rst clip", clip, 0);
      check("rst missing", missing, 0);
      check("rst overrun", frame_overrun, 0);
      reset = 1'b1;
      @(negedge clk);

      load(2'b11, 1000, -300);
      run_frame("basic", 0);
      load(2'b11, 32767, 32767);
      run_frame("pos_clip", 0);
      load(2'b11, -32768, -32768);
      run_frame("neg_clip", 0);
      volume = 3'd1;
      load(2'b11, 32767, 32767);
      run_frame("vol1", 0);
      volume = 3'd0;

      load(2'b11, 400, 200);
      run_frame("fresh", 0);
      load(2'b01, 100, 0);
      run_frame("stale", 0);
      pulse_clear();
      check("clear missing", missing, m_missing);

      play = 1'b0;
      load(2'b11, 5, 6);
      run_frame("muted", 0);
      play = 1'b1;
      load(2'b11, 7, 8);
      run_frame("play_drop", 1);

      load(2'b11, 10, 20);
      run_frame("overrun", 2);

      // reset asserted while the mix is in SUM
      load(2'b11, 50, 60);
      @(negedge clk);
      New_Frame = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("midrst sample", $signed(sample_out), 0);
      check("midrst gen", generate_next_sample, 0);
      check("midrst clip", clip, 0);
      check("midrst missing", missing, 0);
      check("midrst overrun", frame_overrun, 0);
      New_Frame = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_frame("after_rst", 0);
      pulse_clear();

      for (int it = 0; it < 30; it++) begin
         voice_enable = V'($urandom_range(0, 3));
         volume       = VW'($urandom_range(0, 7));
         mask         = V'($urandom_range(0, 3));
         play         = ($urandom_range(0, 3) != 0);
         a = $urandom_range(0, 65535) - 32768;
         b = $urandom_range(0, 65535) - 32768;
         if ($urandom_range(0, 3) == 0) a = 32767;
         if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
         if ($urandom_range(0, 4) == 0) pulse_clear();
         load(mask, a, b);
         run_frame($sformatf("rand%0d", it), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
